// File: rtl/operand_sequencer_pkg.sv
// operand_sequencer_pkg
// Shared definitions for the operand sequencer slice: the FSM state type,
// the operand/result data width and the width of the adder wait counter.
package operand_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE_A,
        LOAD_B,
        WAIT,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/result_reg.sv
// result_reg
// Holds the captured adder result and its valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   capture     : load sum/cout and raise res_valid this cycle
//   sum, cout   : adder outputs to capture
//   res_ready   : consumer accepts the result
//   res_data    : captured result byte
//   res_carry   : captured carry-out
//   res_valid   : result available
// Optional macro OPERAND_SEQ_SAT_EN: a carry on capture saturates res_data
// to 8'hFF (res_carry still reports the carry).
module result_reg
    import operand_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] sum,
    input  logic              cout,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_valid
);

    logic [DATA_W-1:0] data_in;

    always_comb begin
        data_in = sum;
`ifdef OPERAND_SEQ_SAT_EN
        if (cout) begin
            data_in = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_carry <= 1'b0;
            res_valid <= 1'b0;
        end else if (capture) begin
            res_data  <= data_in;
            res_carry <= cout;
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer
// Accepts two operand bytes (A then B) on a valid/ready input, presents them
// registered to an external 8-bit adder, waits ADD_LAT cycles for the adder,
// captures sum/carry and holds them until the consumer accepts.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid    : operand byte input (A first, then B)
//   in_ready            : operand accepted this cycle when in_valid is high
//   op_a, op_b          : registered operands to the adder
//   add_sum, add_cout   : adder result
//   res_data/res_carry  : captured result
//   res_valid/res_ready : result handshake
//   op_count            : completed transactions, wraps at 8 bits
// Parameter ADD_LAT (1..15): cycles operands are held before capture.
// Optional macro OPERAND_SEQ_SAT_EN: saturate res_data to 8'hFF on carry.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int unsigned ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ADD_LAT - 1);

    seq_state_t        state, state_nx;
    logic [CNT_W-1:0]  wait_cnt;
    logic              load_a, load_b, capture, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_A;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        load_a   = 1'b0;
        load_b   = 1'b0;
        capture  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_a   = 1'b1;
                    state_nx = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_b   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                // The next A is only accepted after returning to IDLE_A,
                // i.e. the cycle after the result handshake.
                if (res_valid && res_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE_A;
                end
            end
            default: state_nx = IDLE_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            wait_cnt <= '0;
            op_count <= '0;
        end else begin
            if (load_a) begin
                op_a <= in_data;
            end
            if (load_b) begin
                op_b     <= in_data;
                wait_cnt <= LAT_LOAD;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (done) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    result_reg u_result_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .sum       (add_sum),
        .cout      (add_cout),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_valid (res_valid)
    );

endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer
// Self-checking bench: table of operand pairs, directed multi-cycle cases
// (stall, reset mid-transaction, wrap, latency) and randomized transactions
// checked against an arithmetic reference. Two instances: ADD_LAT=1 and 4.
module tb_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic [7:0] in_data, op_a, op_b, add_sum, res_data, op_count;
    logic       in_valid, in_ready, add_cout, res_carry, res_valid, res_ready;

    logic [7:0] in_data4, op_a4, op_b4, add_sum4, res_data4, op_count4;
    logic       in_valid4, in_ready4, add_cout4, res_carry4, res_valid4, res_ready4;

    // External adders
    assign {add_cout, add_sum}   = {1'b0, op_a}  + {1'b0, op_b};
    assign {add_cout4, add_sum4} = {1'b0, op_a4} + {1'b0, op_b4};

    operand_sequencer #(.ADD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .add_sum(add_sum),
        .add_cout(add_cout), .res_data(res_data), .res_carry(res_carry),
        .res_valid(res_valid), .res_ready(res_ready), .op_count(op_count)
    );

    operand_sequencer #(.ADD_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .op_a(op_a4), .op_b(op_b4), .add_sum(add_sum4),
        .add_cout(add_cout4), .res_data(res_data4), .res_carry(res_carry4),
        .res_valid(res_valid4), .res_ready(res_ready4), .op_count(op_count4)
    );

    int checks = 0;
    int errs   = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errs++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: plain integer addition, optional saturation on overflow.
    function automatic logic [8:0] ref_add(input int a, input int b);
        int s;
        logic [7:0] d;
        logic c;
        s = a + b;
        c = (s > 255);
        d = 8'(s % 256);
`ifdef OPERAND_SEQ_SAT_EN
        if (c) d = 8'hFF;
`endif
        return {c, d};
    endfunction

    task automatic send(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) timeout("send");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (res_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) timeout(name);
    endtask

    // Collect one result: check it, stall, handshake, check the count step.
    task automatic get(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic ec,
                       input int stall, input string name);
        wait_valid(name);
        chk({name, "_data"}, 32'(res_data), 32'(ed));
        chk({name, "_carry"}, 32'(res_carry), 32'(ec));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({name, "_stall_valid"}, 32'(res_valid), 32'd1);
            chk({name, "_stall_data"}, 32'(res_data), 32'(ed));
            chk({name, "_stall_opa"}, 32'(op_a), 32'(a));
            chk({name, "_stall_opb"}, 32'(op_b), 32'(b));
            chk({name, "_stall_inready"}, 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        chk({name, "_valid_drop"}, 32'(res_valid), 32'd0);
        chk({name, "_count"}, 32'(op_count), 32'(exp_cnt));
        chk({name, "_inready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] raw;   // unsaturated {carry, sum}
    } vec_t;

    vec_t tbl[6];
    logic [8:0] r;
    logic [7:0] ta, tb_b, ed;
    int cyc;

    initial begin
        tbl[0] = '{8'h35, 8'h4A, 9'h07F};
        tbl[1] = '{8'hC8, 8'h64, 9'h12C};
        tbl[2] = '{8'hFF, 8'h01, 9'h100};
        tbl[3] = '{8'h00, 8'h00, 9'h000};
        tbl[4] = '{8'hFF, 8'hFF, 9'h1FE};
        tbl[5] = '{8'h80, 8'h7F, 9'h0FF};

        in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        in_valid4 = 1'b0; in_data4 = '0; res_ready4 = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_opa", 32'(op_a), 32'd0);
        chk("rst_opb", 32'(op_b), 32'd0);
        chk("rst_resdata", 32'(res_data), 32'd0);
        chk("rst_rescarry", 32'(res_carry), 32'd0);
        chk("rst_resvalid", 32'(res_valid), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        do_reset();
        chk("inready_after_reset", 32'(in_ready), 32'd1);

        // Reset asserted in WAIT abandons the transaction.
        send(8'h35);
        send(8'h4A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_opa", 32'(op_a), 32'd0);
        chk("midrst_opb", 32'(op_b), 32'd0);
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_data", 32'(res_data), 32'd0);
        chk("midrst_inready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("midrst_novalid", 32'(res_valid), 32'd0);
        end
        chk("midrst_count", 32'(op_count), 32'd0);

        // Basic transaction with latency measured from the B-accept cycle.
        send(8'h35);
        in_valid = 1'b1;
        in_data  = 8'h4A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (res_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("lat1_cycles", 32'(cyc), 32'd2);
        get(8'h35, 8'h4A, 8'h7F, 1'b0, 0, "basic");

        // Table of operand pairs.
        for (int i = 0; i < 6; i++) begin
            ed = tbl[i].raw[7:0];
`ifdef OPERAND_SEQ_SAT_EN
            if (tbl[i].raw[8]) ed = 8'hFF;
`endif
            send(tbl[i].a);
            send(tbl[i].b);
            get(tbl[i].a, tbl[i].b, ed, tbl[i].raw[8], i % 3, $sformatf("tbl%0d", i));
        end

        // Long stall with in_valid asserted: input must be ignored.
        send(8'h11);
        send(8'h22);
        wait_valid("hold");
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'h33);
            chk("hold_opa", 32'(op_a), 32'h11);
            chk("hold_opb", 32'(op_b), 32'h22);
            chk("hold_inready", 32'(in_ready), 32'd0);
            chk("hold_count", 32'(op_count), 32'(exp_cnt));
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("hold_count_inc", 32'(op_count), 32'(exp_cnt));
        @(posedge clk); #1;
        chk("hold_count_single", 32'(op_count), 32'(exp_cnt));
        chk("hold_opa_kept", 32'(op_a), 32'h11);
        chk("hold_novalid", 32'(res_valid), 32'd0);

        // Randomized transactions with idle gaps and stalls.
        for (int t = 0; t < 150; t++) begin
            ta   = 8'($urandom);
            tb_b = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(ta);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(tb_b);
            r = ref_add(int'(ta), int'(tb_b));
            get(ta, tb_b, r[7:0], r[8], int'($urandom_range(0, 3)), "rand");
        end

        // 256 back-to-back transactions wrap the counter.
        do_reset();
        for (int t = 0; t < 256; t++) begin
            ta   = 8'(t);
            tb_b = 8'(255 - t);
            send(ta);
            send(tb_b);
            r = ref_add(t, 255 - t);
            get(ta, tb_b, r[7:0], r[8], 0, "wrap");
            if (t == 254) chk("wrap_ff", 32'(op_count), 32'hFF);
        end
        chk("wrap_zero", 32'(op_count), 32'd0);

        // ADD_LAT=4 instance: latency and result.
        in_valid4 = 1'b1;
        in_data4  = 8'h35;
        @(posedge clk); #1;
        in_data4  = 8'h4A;
        chk("lat4_inready_b", 32'(in_ready4), 32'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        cyc = 1;
        while (res_valid4 !== 1'b1 && cyc < 40) begin
            chk("lat4_inready_wait", 32'(in_ready4), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("lat4_cycles", 32'(cyc), 32'd5);
        chk("lat4_data", 32'(res_data4), 32'h7F);
        chk("lat4_carry", 32'(res_carry4), 32'd0);
        res_ready4 = 1'b1;
        @(posedge clk); #1;
        res_ready4 = 1'b0;
        chk("lat4_count", 32'(op_count4), 32'd1);
        chk("lat4_valid_drop", 32'(res_valid4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter ADD_LAT, default 1: clock cycles operands are held stable on op_a/op_b before the sum is captured (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  8  operand byte; first A, then B.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port op_a  output  8  registered operand A to the 8-bit adder.
REQ-008 SHALL have port op_b  output  8  registered operand B to the 8-bit adder.
REQ-009 SHALL have port add_sum  input  8  sum returned by the adder.
REQ-010 SHALL have port add_cout  input  1  carry-out returned by the adder.
REQ-011 SHALL have port res_data  output  8  captured result byte.
REQ-012 SHALL have port res_carry  output  1  captured carry-out.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  consumer accepts result.
REQ-015 SHALL have port op_count  output  8  completed-transaction counter.

Function
REQ-016 SHALL implement FSM states IDLE_A, LOAD_B, WAIT, HOLD.
REQ-017 in_ready SHALL be 1 in IDLE_A and LOAD_B only, 0 in WAIT and HOLD.
REQ-018 IDLE_A: on in_valid&in_ready, op_a <= in_data, go to LOAD_B.
REQ-019 LOAD_B: on in_valid&in_ready, op_b <= in_data, load wait counter with ADD_LAT-1, go to WAIT.
REQ-020 WAIT: counter decrements each cycle; at counter==0, res_data <= add_sum, res_carry <= add_cout, res_valid <= 1, go to HOLD.
REQ-021 Latency from B-accept edge to res_valid high SHALL be exactly ADD_LAT+1 cycles.
REQ-022 HOLD: res_data, res_carry, op_a, op_b SHALL stay stable while res_valid&!res_ready.
REQ-023 HOLD: on res_valid&res_ready, res_valid <= 0, op_count <= op_count+1 (wraps 0xFF->0x00), go to IDLE_A.
REQ-024 No result-to-new-operand overlap: the next A is accepted no earlier than the cycle after the result handshake.
REQ-025 in_valid without in_ready SHALL be ignored; data not consumed.
REQ-026 op_a/op_b SHALL hold their last values outside load events.

Reset
REQ-027 On rst_n low, immediately: state IDLE_A, op_a=0, op_b=0, res_data=0, res_carry=0, res_valid=0, op_count=0, wait counter=0.
REQ-028 Reset asserted mid-transaction SHALL abandon it without incrementing op_count; no res_valid pulse after release.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro OPERAND_SEQ_SAT_EN defined: on capture with add_cout=1, res_data SHALL be 8'hFF (saturated), res_carry still 1.
REQ-031 Macro OPERAND_SEQ_SAT_EN undefined: res_data SHALL always equal the captured add_sum (modulo 256).

Structure
REQ-032 Shared package SHALL hold the FSM state typedef, the data width constant (8) and the wait-counter width constant (4).
REQ-033 A single sub-module result_reg SHALL hold res_data/res_carry/res_valid with its capture/handshake logic. The adder itself stays outside this block.

Verification
REQ-034 ADD_LAT=1, A=0x35, B=0x4A, adder correct -> res_data=0x7F, res_carry=0, res_valid 2 cycles after B accept, op_count 0->1 on handshake.
REQ-035 A=0xC8, B=0x64 -> res_carry=1; res_data=0x2C without OPERAND_SEQ_SAT_EN, 0xFF with it.
REQ-036 res_ready held 0 for 10 cycles in HOLD -> outputs stable, in_ready=0, in_valid ignored; then res_ready=1 -> single count increment.
REQ-037 rst_n pulsed low during WAIT -> all outputs 0 asynchronously, state IDLE_A, no result emitted, op_count unchanged at 0.
REQ-038 256 back-to-back transactions -> op_count wraps to 0x00. ADD_LAT=4 -> res_valid exactly 5 cycles after B accept.
